// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and shared-memory port signals around mem_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_mode;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;

    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        stall_F;
    logic        stall_M;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_mode, d_addr, d_wdata,
        input  mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_req, mem_we, mem_mode, mem_addr, mem_wdata,
        output stall_F, stall_M
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_mode, d_addr, d_wdata,
        output mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_req, mem_we, mem_mode, mem_addr, mem_wdata,
        input  stall_F, stall_M
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data) for a single shared memory port,
// one transaction in flight, with a starvation limit that protects fetch from data.
//
// state | meaning
// IDLE  | no transaction outstanding; arbitration happens here
// FETCH | fetch request on the memory port, waiting for mem_ack
// DATA  | data load/store on the memory port, waiting for mem_ack
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [2:0] LIMIT     = 3'(STARVE_LIMIT);
    localparam logic [2:0] MODE_WORD = 3'b010;

    state_t      state_q, state_d;
    logic [2:0]  starve_q, starve_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [2:0]  mem_mode_q, mem_mode_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_ready_q, if_ready_d;
    logic        d_ready_q, d_ready_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        data_ok;

    // Data wins arbitration only while fetch has not yet used up its patience.
    assign data_ok = bus.d_req && (starve_q < LIMIT);

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_mode_d  = mem_mode_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        if (!bus.if_req) begin
            starve_d = 3'd0;
        end

        case (state_q)
            IDLE: begin
                if (data_ok) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_mode_d  = bus.d_mode;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    if (bus.if_req) begin
                        starve_d = starve_q + 3'd1;
                    end
                end else if (bus.if_req) begin
                    state_d     = FETCH;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_mode_d  = MODE_WORD;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = 32'd0;
                    starve_d    = 3'd0;
                end
            end

            FETCH: begin
                if (bus.mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_rdata_d = bus.mem_rdata;
                    if_ready_d = 1'b1;
                end
            end

            DATA: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    d_ready_d = 1'b1;
                    // Stores complete with a pulse but leave the load result untouched.
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            starve_q    <= 3'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_mode_q  <= 3'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_mode_q  <= mem_mode_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_mode  = mem_mode_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    assign bus.stall_F = bus.if_req & ~if_ready_q;
    assign bus.stall_M = bus.d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven and outputs checked on the falling
// edge, memory acknowledges supplied by hand with known delays and data.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'd0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_mode    = 3'd0;
        bus.d_addr    = 32'd0;
        bus.d_wdata   = 32'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] last_d;
        logic [31:0] exp_addr;
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        reset = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_mode", {29'd0, bus.mem_mode}, 32'd0);
        chk("rst_ready",    {30'd0, bus.if_ready, bus.d_ready}, 32'd0);
        chk("rst_rdata",    bus.if_rdata | bus.d_rdata, 32'd0);
        reset = 1'b1;

        // Lone fetch, ack one cycle after mem_req
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        #1 chk("f_stall_pre", {31'd0, bus.stall_F}, 32'd1);
        @(negedge clk);
        chk("f_mem_req",  {31'd0, bus.mem_req}, 32'd1);
        chk("f_mem_addr", bus.mem_addr, 32'h10);
        chk("f_mem_we",   {31'd0, bus.mem_we}, 32'd0);
        chk("f_mem_mode", {29'd0, bus.mem_mode}, 32'd2);
        chk("f_stall",    {31'd0, bus.stall_F}, 32'd1);
        chk("f_ready_early", {31'd0, bus.if_ready}, 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0050_0093;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("f_ready",    {31'd0, bus.if_ready}, 32'd1);
        chk("f_rdata",    bus.if_rdata, 32'h0050_0093);
        chk("f_stall_rdy", {31'd0, bus.stall_F}, 32'd0);
        chk("f_req_drop", {31'd0, bus.mem_req}, 32'd0);
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("f_pulse_end", {31'd0, bus.if_ready}, 32'd0);
        chk("f_rdata_hold", bus.if_rdata, 32'h0050_0093);

        // Simultaneous fetch and data load: data first, fetch right after
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0040;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_mode  = 3'b010;
        bus.d_addr  = 32'h0000_0100;
        @(negedge clk);
        chk("s_first_addr", bus.mem_addr, 32'h100);
        chk("s_stall_F", {31'd0, bus.stall_F}, 32'd1);
        chk("s_stall_M", {31'd0, bus.stall_M}, 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("s_d_ready", {31'd0, bus.d_ready}, 32'd1);
        chk("s_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        chk("s_if_ready", {31'd0, bus.if_ready}, 32'd0);
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("s_fetch_req",  {31'd0, bus.mem_req}, 32'd1);
        chk("s_fetch_addr", bus.mem_addr, 32'h40);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_2222;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("s_f_ready", {31'd0, bus.if_ready}, 32'd1);
        chk("s_f_rdata", bus.if_rdata, 32'h1111_2222);
        bus.if_req = 1'b0;
        @(negedge clk);

        // Starvation: D,D,D,D,F,D with both requests held
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0080;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h0000_0200;
        for (int g = 0; g < 6; g++) begin
            exp_addr = (g == 4) ? 32'h80 : 32'h200;
            @(negedge clk);
            chk($sformatf("st_grant%0d", g), bus.mem_addr, exp_addr);
            chk($sformatf("st_req%0d", g), {31'd0, bus.mem_req}, 32'd1);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'h0000_1000 + 32'(g);
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (g == 4) begin
                chk("st_f_ready", {30'd0, bus.if_ready, bus.d_ready}, 32'd2);
                chk("st_f_rdata", bus.if_rdata, 32'h0000_1004);
            end else begin
                chk($sformatf("st_d_ready%0d", g), {30'd0, bus.if_ready, bus.d_ready}, 32'd1);
                chk($sformatf("st_d_rdata%0d", g), bus.d_rdata, 32'h0000_1000 + 32'(g));
            end
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);
        last_d = 32'h0000_1005;

        // Store held across a 5-cycle ack delay
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_mode  = 3'b000;
        bus.d_addr  = 32'h0000_0020;
        bus.d_wdata = 32'h0000_00A5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("w_req%0d", i), {31'd0, bus.mem_req}, 32'd1);
            chk($sformatf("w_ctl%0d", i), {28'd0, bus.mem_we, bus.mem_mode}, 32'h8);
            chk($sformatf("w_addr%0d", i), bus.mem_addr, 32'h20);
            chk($sformatf("w_wdata%0d", i), bus.mem_wdata, 32'hA5);
            chk($sformatf("w_noready%0d", i), {31'd0, bus.d_ready}, 32'd0);
            if (i == 4) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hFFFF_FFFF;
            end
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("w_ready", {31'd0, bus.d_ready}, 32'd1);
        chk("w_rdata_keep", bus.d_rdata, last_d);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        @(negedge clk);
        chk("w_pulse_once", {31'd0, bus.d_ready}, 32'd0);

        // Spurious ack in IDLE, then fetch whose requester drops mid-flight
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("sp_ready", {30'd0, bus.if_ready, bus.d_ready}, 32'd0);
        chk("sp_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("sp_rdata", bus.if_rdata, 32'h0000_1004);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0300;
        @(negedge clk);
        chk("dr_req",  {31'd0, bus.mem_req}, 32'd1);
        chk("dr_addr", bus.mem_addr, 32'h300);
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("dr_hold", {31'd0, bus.mem_req}, 32'd1);
        chk("dr_stall", {31'd0, bus.stall_F}, 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("dr_ready", {31'd0, bus.if_ready}, 32'd1);
        chk("dr_rdata", bus.if_rdata, 32'hCAFE_F00D);
        @(negedge clk);
        chk("dr_idle", {30'd0, bus.mem_req, bus.if_ready}, 32'd0);

        // Asynchronous reset while a fetch is outstanding
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0400;
        @(negedge clk);
        chk("ar_pre_req", {31'd0, bus.mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ar_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("ar_ready", {30'd0, bus.if_ready, bus.d_ready}, 32'd0);
        chk("ar_addr",  bus.mem_addr, 32'd0);
        chk("ar_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
        @(negedge clk);
        chk("ar_held", {31'd0, bus.mem_req}, 32'd0);
        reset       = 1'b1;
        bus.if_addr = 32'h0000_0500;
        @(negedge clk);
        chk("ar_new_req",  {31'd0, bus.mem_req}, 32'd1);
        chk("ar_new_addr", bus.mem_addr, 32'h500);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0077;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        chk("ar_new_ready", {31'd0, bus.if_ready}, 32'd1);
        chk("ar_new_rdata", bus.if_rdata, 32'h77);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
